// File: rtl/qpp_pingpong_interleaver.sv
// qpp_pingpong_interleaver: two ping-pong banks written in natural order, read in QPP order pi(i)=(f1*i+f2*i*i) mod K
module qpp_pingpong_interleaver #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 13,
  parameter int MAX_K  = 6144,
  parameter int MIN_K  = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              blk_start,
  input  logic [ADDR_W-1:0] blk_k,
  input  logic [ADDR_W-1:0] blk_f1,
  input  logic [ADDR_W-1:0] blk_f2,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              out_first,
  output logic              out_last,
  output logic              err
);
  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_e;
  typedef enum logic {W_IDLE, W_FILL} wst_e;
  typedef enum logic [1:0] {R_IDLE, R_SETUP, R_DRAIN} rs_e;
  function automatic logic [ADDR_W-1:0] addmod(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] k);
    logic [ADDR_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s >= {1'b0, k} ? ADDR_W'(s - {1'b0, k}) : s[ADDR_W-1:0];
  endfunction
  logic [DATA_W-1:0] mem_q [2][MAX_K];
  logic [ADDR_W-1:0] k_q [2], f1_q [2], f2_q [2];
  bank_e st_q [2], st_d [2];
  wst_e wst_q, wst_d;
  rs_e rs_q, rs_d;
  logic wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d, pi_q, pi_d, g_q, g_d, d_q, d_d;
  // skid entries packed as {first, last, data}; h is the head driving the outputs
  logic [DATA_W+1:0] h_q, h_d, t_q, t_d, new_e;
  logic [1:0] cnt_q, cnt_d;
  logic err_q, blk_ok, accept, we, last_w, pop, issue, last_r;
  assign blk_ok = blk_k >= ADDR_W'(MIN_K) && blk_k <= ADDR_W'(MAX_K) && blk_f1 < blk_k && blk_f2 < blk_k;
  assign accept = blk_start && wst_q == W_IDLE && st_q[wptr_q] == B_EMPTY && blk_ok;
  assign we = wst_q == W_FILL && in_valid;
  assign last_w = we && wcnt_q == k_q[wptr_q] - ADDR_W'(1);
  assign pop = out_valid && out_ready;
  // issue only when the read lands in a free skid slot on the next edge
  assign issue = rs_q == R_DRAIN && (cnt_q != 2'd2 || pop);
  assign last_r = issue && rcnt_q == k_q[rptr_q] - ADDR_W'(1);
  assign new_e = {rcnt_q == '0, rcnt_q == k_q[rptr_q] - ADDR_W'(1), mem_q[rptr_q][pi_q]};
  assign in_ready = wst_q == W_FILL;
  assign out_valid = cnt_q != 2'd0;
  assign data_out = h_q[DATA_W-1:0];
  assign out_first = out_valid && h_q[DATA_W+1];
  assign out_last = out_valid && h_q[DATA_W];
  assign err = err_q;
  always_comb begin
    st_d = st_q;
    wst_d = wst_q;
    wptr_d = wptr_q;
    wcnt_d = wcnt_q;
    rs_d = rs_q;
    rptr_d = rptr_q;
    rcnt_d = rcnt_q;
    pi_d = pi_q;
    g_d = g_q;
    d_d = d_q;
    if (accept) begin
      st_d[wptr_q] = B_FILLING;
      wcnt_d = '0;
      wst_d = W_FILL;
    end
    if (we) wcnt_d = wcnt_q + ADDR_W'(1);
    if (last_w) begin
      st_d[wptr_q] = B_FULL;
      wptr_d = ~wptr_q;
      wst_d = W_IDLE;
    end
    if (rs_q == R_IDLE && st_q[rptr_q] == B_FULL) begin
      st_d[rptr_q] = B_DRAINING;
      rs_d = R_SETUP;
    end
    if (rs_q == R_SETUP) begin
      pi_d = '0;
      g_d = addmod(f1_q[rptr_q], f2_q[rptr_q], k_q[rptr_q]);
      d_d = addmod(f2_q[rptr_q], f2_q[rptr_q], k_q[rptr_q]);
      rcnt_d = '0;
      rs_d = R_DRAIN;
    end
    if (issue) begin
      pi_d = addmod(pi_q, g_q, k_q[rptr_q]);
      g_d = addmod(g_q, d_q, k_q[rptr_q]);
      rcnt_d = rcnt_q + ADDR_W'(1);
    end
    if (last_r) begin
      st_d[rptr_q] = B_EMPTY;
      rptr_d = ~rptr_q;
      rs_d = R_IDLE;
    end
  end
  always_comb begin
    h_d = pop ? t_q : h_q;
    t_d = t_q;
    cnt_d = cnt_q + 2'(issue) - 2'(pop);
    if (issue && (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop))) h_d = new_e;
    else if (issue) t_d = new_e;
  end
  always_ff @(posedge clk) begin
    if (we) mem_q[wptr_q][wcnt_q] <= data_in;
    if (accept) begin
      k_q[wptr_q] <= blk_k;
      f1_q[wptr_q] <= blk_f1;
      f2_q[wptr_q] <= blk_f2;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= '{default: B_EMPTY};
      wst_q <= W_IDLE;
      rs_q <= R_IDLE;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      wcnt_q <= '0;
      rcnt_q <= '0;
      pi_q <= '0;
      g_q <= '0;
      d_q <= '0;
      h_q <= '0;
      t_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      st_q <= st_d;
      wst_q <= wst_d;
      rs_q <= rs_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
      pi_q <= pi_d;
      g_q <= g_d;
      d_q <= d_d;
      h_q <= h_d;
      t_q <= t_d;
      cnt_q <= cnt_d;
      err_q <= blk_start && !accept;
    end
  end
endmodule

// File: tb/tb_qpp_pingpong_interleaver.sv
// tb_qpp_pingpong_interleaver: scoreboard bench for the QPP ping-pong interleaver
module tb_qpp_pingpong_interleaver;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 13;
  localparam int MAX_K = 6144;
  typedef struct packed { logic [DATA_W-1:0] d; logic f; logic l; } exp_t;
  typedef struct { int k; int f1; int f2; } blk_t;
  logic clk = 1'b0, reset = 1'b1, blk_start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [ADDR_W-1:0] blk_k = '0, blk_f1 = '0, blk_f2 = '0;
  logic [DATA_W-1:0] data_in = '0, data_out;
  logic in_ready, out_valid, out_first, out_last, err;
  exp_t sb[$];
  exp_t hold;
  logic hold_v = 1'b0, lat_arm = 1'b0, rnd_mode = 1'b0;
  logic [DATA_W-1:0] blkdat [MAX_K];
  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0, lat_cyc = 0;
  qpp_pingpong_interleaver #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_K(MAX_K), .MIN_K(40)) dut (
    .clk(clk), .reset(reset), .blk_start(blk_start), .blk_k(blk_k), .blk_f1(blk_f1), .blk_f2(blk_f2),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .out_first(out_first), .out_last(out_last), .err(err)
  );
  always #5 clk = ~clk;
  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction
  function automatic int qpp(int i, int k, int f1, int f2);
    longint t;
    t = (longint'(f1) * i + longint'(f2) * i * i) % k;
    return int'(t);
  endfunction
  function automatic void mon();
    exp_t cur, e;
    cur = {data_out, out_first, out_last};
    if (out_valid && hold_v) chk("stall_hold", cur, hold);
    if (lat_arm && out_valid && out_first) begin
      lat_cyc = cyc;
      lat_arm = 1'b0;
    end
    hold_v = out_valid && !out_ready;
    hold = cur;
    if (out_valid && out_ready) begin
      chk("out_queue_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_sym", cur, e);
      end
    end
  endfunction
  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    cyc++;
    #1;
    if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
  endtask
  task automatic start(int k, int f1, int f2, logic exp_err);
    blk_k = ADDR_W'(k);
    blk_f1 = ADDR_W'(f1);
    blk_f2 = ADDR_W'(f2);
    blk_start = 1'b1;
    tick();
    blk_start = 1'b0;
    chk("err", err, exp_err);
    if (!exp_err)
      for (int j = 0; j < k; j++) sb.push_back({blkdat[qpp(j, k, f1, f2)], j == 0, j == k - 1});
  endtask
  task automatic feed(int n, output int stalls);
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      data_in = blkdat[i];
      while (!in_ready && stalls < 20000) begin
        tick();
        stalls++;
      end
      tick();
      acc_cyc = cyc;
    end
    in_valid = 1'b0;
  endtask
  task automatic run_block(int k, int f1, int f2, logic rnd);
    int st;
    for (int i = 0; i < k; i++) blkdat[i] = rnd ? DATA_W'($urandom) : DATA_W'(i);
    start(k, f1, f2, 1'b0);
    feed(k, st);
    chk("in_stalls", st, 0);
  endtask
  task automatic drain(int limit);
    int n = 0;
    while (sb.size() > 0 && n < limit) begin
      tick();
      n++;
    end
    chk("drain_done", sb.size(), 0);
    tick();
    tick();
    chk("idle_valid", out_valid, 0);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    sb.delete();
    hold_v = 1'b0;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_first", out_first, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_err", err, 0);
    chk("rst_data_out", data_out, 0);
    reset = 1'b0;
  endtask
  initial begin
    blk_t rej[4];
    blk_t blocks[2];
    int st;
    rej[0] = '{39, 3, 10};
    rej[1] = '{6145, 3, 10};
    rej[2] = '{40, 40, 10};
    rej[3] = '{40, 3, 40};
    blocks[0] = '{40, 3, 10};
    blocks[1] = '{6144, 263, 480};
    out_ready = 1'b1;
    tick();
    do_reset();
    foreach (rej[i]) begin
      start(rej[i].k, rej[i].f1, rej[i].f2, 1'b1);
      chk("rej_in_ready", in_ready, 0);
      tick();
      chk("err_pulse_end", err, 0);
      chk("rej_no_out", out_valid, 0);
    end
    lat_cyc = 0;
    lat_arm = 1'b1;
    run_block(40, 3, 10, 1'b0);
    drain(200);
    chk("latency", lat_cyc - acc_cyc, 3);
    foreach (blocks[i]) run_block(blocks[i].k, blocks[i].f1, blocks[i].f2, 1'b1);
    drain(20000);
    rnd_mode = 1'b1;
    run_block(1056, 17, 66, 1'b1);
    drain(10000);
    rnd_mode = 1'b0;
    out_ready = 1'b0;
    run_block(40, 3, 10, 1'b1);
    run_block(48, 7, 12, 1'b1);
    chk("full_in_ready", in_ready, 0);
    tick();
    tick();
    start(40, 3, 10, 1'b1);
    chk("full_in_ready_after_err", in_ready, 0);
    out_ready = 1'b1;
    drain(1000);
    for (int i = 0; i < 40; i++) blkdat[i] = DATA_W'($urandom);
    start(40, 3, 10, 1'b0);
    feed(20, st);
    do_reset();
    run_block(40, 3, 10, 1'b1);
    repeat (15) tick();
    do_reset();
    lat_cyc = 0;
    lat_arm = 1'b1;
    run_block(40, 3, 10, 1'b0);
    drain(200);
    chk("latency_after_reset", lat_cyc - acc_cyc, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
